// File: rtl/serial_adder_pkg.sv
// Shared types for the serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
// The sub request signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif

endinterface

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder cell; chained to form the per-slice ripple datapath.
module fa_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands processed BITS_PER_CYCLE bits per clock, LSB slice first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int unsigned K     = BITS_PER_CYCLE;
  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_cfg
    $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             done_q, done_d, busy_q, busy_d;

  logic [K-1:0]       slice_c;
  logic [WIDTH+K-1:0] shifted_c;
  logic               chain_co_c, chain_msb_ci_c;

  // Ripple chain across the low K bits; each stage owns its carry signals.
  for (genvar gi = 0; gi < int'(K); gi++) begin : g_bit
    logic ci, co, s;
    if (gi == 0) begin : g_first
      assign ci = carry_q;
    end else begin : g_next
      assign ci = g_bit[gi-1].co;
    end
    fa_bit u_fa (
      .a_i  (a_q[gi]),
      .b_i  (b_q[gi]),
      .ci_i (ci),
      .s_o  (s),
      .co_o (co)
    );
    assign slice_c[gi] = s;
  end

  assign chain_co_c     = g_bit[K-1].co;
  assign chain_msb_ci_c = g_bit[K-1].ci;
  assign shifted_c      = {slice_c, sum_sh_q} >> K;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
          // a - b computed as a + ~b + 1
          if (bus.sub) begin
            b_d     = ~bus.b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> K;
        b_d      = b_q >> K;
        carry_d  = chain_co_c;
        cnt_d    = cnt_q + CW'(1);
        sum_sh_d = shifted_c[WIDTH-1:0];
        if (cnt_q == CW'(STEPS - 1)) begin
          sum_d   = shifted_c[WIDTH-1:0];
          cout_d  = chain_co_c;
          ovf_d   = chain_co_c ^ chain_msb_ci_c;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, hand-written corner sequences, random ops vs arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(1)) if1  ();
  serial_adder_if #(.WIDTH(8)) if8a ();
  serial_adder_if #(.WIDTH(8)) if8b ();

  serial_adder #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_w1 (.clk(clk), .rst(rst), .bus(if1));
  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_k1 (.clk(clk), .rst(rst), .bus(if8a));
  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_k4 (.clk(clk), .rst(rst), .bus(if8b));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         sel;   // 0: W8/K1, 1: W8/K4, 2: W1/K1
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on w-bit values.
  task automatic model(input int w, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output logic [7:0] s, output logic co, output logic ov);
    int unsigned mask, av, bv, full;
    mask = (32'd1 << w) - 1;
    av   = a & mask;
    bv   = sub ? (~b & mask) : (b & mask);
    full = av + bv + ((sub ? 1 : cin) ? 1 : 0);
    s    = 8'(full & mask);
    co   = full[w];
    ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
  endtask

  function automatic int steps_of(input int sel);
    case (sel)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int width_of(input int sel);
    return (sel == 2) ? 1 : 8;
  endfunction

  task automatic set_in(input int sel, input logic [7:0] a, input logic [7:0] b, input logic cin);
    case (sel)
      0:       begin if8a.a = a; if8a.b = b; if8a.cin = cin; end
      1:       begin if8b.a = a; if8b.b = b; if8b.cin = cin; end
      default: begin if1.a = a[0]; if1.b = b[0]; if1.cin = cin; end
    endcase
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic set_sub(input int sel, input logic sub);
    case (sel)
      0:       if8a.sub = sub;
      1:       if8b.sub = sub;
      default: if1.sub = sub;
    endcase
  endtask
`endif

  task automatic set_start(input int sel, input logic st);
    case (sel)
      0:       if8a.start = st;
      1:       if8b.start = st;
      default: if1.start = st;
    endcase
  endtask

  function automatic logic [7:0] rd_sum(input int sel);
    case (sel)
      0:       return if8a.sum;
      1:       return if8b.sum;
      default: return {7'b0, if1.sum};
    endcase
  endfunction

  // {busy, done, cout, ovf}
  function automatic logic [3:0] rd_flags(input int sel);
    case (sel)
      0:       return {if8a.busy, if8a.done, if8a.cout, if8a.ovf};
      1:       return {if8b.busy, if8b.done, if8b.cout, if8b.ovf};
      default: return {if1.busy, if1.done, if1.cout, if1.ovf};
    endcase
  endfunction

  // Runs one operation; called just after a rising edge. hold keeps start high until done.
  task automatic op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic cin,
                    input logic sub, input bit hold,
                    output logic [7:0] s, output logic co, output logic ov, output int lat);
    logic [3:0] f;
    set_in(sel, a, b, cin);
`ifdef SERIAL_ADDER_SUB_EN
    set_sub(sel, sub);
`endif
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    if (!hold) set_start(sel, 1'b0);
    f = rd_flags(sel);
    chk("busy_after_start", 32'(f[3]), 32'd1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      f = rd_flags(sel);
      if (f[2]) begin
        lat = c;
        break;
      end
    end
    set_start(sel, 1'b0);
    chk("done_seen", 32'(lat != 0), 32'd1);
    s  = rd_sum(sel);
    co = f[1];
    ov = f[0];
    chk("busy_during_done", 32'(f[3]), 32'd1);
    @(posedge clk); #1;
    f = rd_flags(sel);
    chk("done_one_cycle", 32'(f[2]), 32'd0);
    chk("busy_fall", 32'(f[3]), 32'd0);
    chk("sum_held", 32'(rd_sum(sel)), 32'(s));
  endtask

  initial begin
    vec_t       tbl[$];
    logic [7:0] s, es;
    logic       co, ov, eco, eov, sub;
    logic [3:0] f;
    int         lat, seen;

    // Full-adder truth table on W1, then spec vectors on W8.
    tbl.push_back('{2, 8'h0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1});
    tbl.push_back('{2, 8'h0, 8'h0, 1'b1, 1'b0, 8'h1, 1'b0, 1'b1, 1});
    tbl.push_back('{2, 8'h0, 8'h1, 1'b0, 1'b0, 8'h1, 1'b0, 1'b0, 1});
    tbl.push_back('{2, 8'h0, 8'h1, 1'b1, 1'b0, 8'h0, 1'b1, 1'b0, 1});
    tbl.push_back('{2, 8'h1, 8'h0, 1'b0, 1'b0, 8'h1, 1'b0, 1'b0, 1});
    tbl.push_back('{2, 8'h1, 8'h0, 1'b1, 1'b0, 8'h0, 1'b1, 1'b0, 1});
    tbl.push_back('{2, 8'h1, 8'h1, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1, 1});
    tbl.push_back('{2, 8'h1, 8'h1, 1'b1, 1'b0, 8'h1, 1'b1, 1'b0, 1});
    tbl.push_back('{0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 8});
    tbl.push_back('{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8});
    tbl.push_back('{0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8});
    tbl.push_back('{1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 2});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back('{0, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 8});
    tbl.push_back('{0, 8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8});
    tbl.push_back('{1, 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 2});
`endif

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(i, 8'h0, 8'h0, 1'b0);
      set_start(i, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
      set_sub(i, 1'b0);
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_flags", 32'(rd_flags(i)), 32'd0);
      chk("reset_sum", 32'(rd_sum(i)), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b0, s, co, ov, lat);
      chk($sformatf("vec%0d_sum", i), 32'(s), 32'(tbl[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(co), 32'(tbl[i].co));
      chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Start held through the whole K=4 run must not relaunch.
    op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, s, co, ov, lat);
    chk("hold_sum", 32'(s), 32'h80);
    chk("hold_latency", 32'(lat), 32'd2);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      f = rd_flags(1);
      if (f[3] || f[2]) seen++;
    end
    chk("hold_no_relaunch", 32'(seen), 32'd0);

    // Abort a K=1 run three steps in.
    op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, s, co, ov, lat);
    chk("pre_abort_sum", 32'(s), 32'h96);
    set_in(0, 8'h33, 8'h44, 1'b0);
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    f = rd_flags(0);
    chk("abort_busy", 32'(f[3]), 32'd0);
    chk("abort_sum", 32'(rd_sum(0)), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      f = rd_flags(0);
      if (f[2]) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    op(0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, s, co, ov, lat);
    chk("post_abort_sum", 32'(s), 32'h03);

    // Random operations on all three instances against the arithmetic model.
    for (int i = 0; i < 45; i++) begin
      int   sel;
      logic [7:0] ra, rb;
      logic rc;
      sel = i % 3;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 1'b0;
`endif
      if (sel == 2) begin
        ra = {7'b0, ra[0]};
        rb = {7'b0, rb[0]};
      end
      model(width_of(sel), ra, rb, rc, sub, es, eco, eov);
      op(sel, ra, rb, rc, sub, 1'b0, s, co, ov, lat);
      chk($sformatf("rnd%0d_sum a=%0h b=%0h c=%0b s=%0b", i, ra, rb, rc, sub), 32'(s), 32'(es));
      chk($sformatf("rnd%0d_cout", i), 32'(co), 32'(eco));
      chk($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(eov));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(steps_of(sel)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder that processes two WIDTH-bit operands in BITS_PER_CYCLE-bit slices, least-significant slice first. A start/busy/done handshake controls each operation, and a registered carry links successive slices. It sits behind the lab's single-bit full-adder cell and reuses that cell's behaviour as its per-bit datapath. It trades latency for area when wide additions are needed.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- BITS_PER_CYCLE, 1, bits added per clock step; must divide WIDTH exactly
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request an operation; sampled only in IDLE
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- cin  input  1  carry-in, captured on the accepting edge
- sub  input  1  subtract request; exists only with SERIAL_ADDER_SUB_EN
- busy  output  1  high while an operation is in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse; result outputs valid from this cycle
- sum  output  WIDTH  result, held until the next operation completes
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

## Operation
- STEPS = WIDTH/BITS_PER_CYCLE. The step counter is max(1,$clog2(STEPS)) bits wide.
- If WIDTH % BITS_PER_CYCLE ≠ 0, elaboration fails with $error.
- FSM has three states: IDLE, RUN, DONE.
- **IDLE:**
  - start=1 captures a, b, cin (and sub) into operand registers.
  - The carry register loads cin (subtract: 1).
  - Counter loads 0; next state is RUN.
- **RUN:**
  - Each cycle adds the low BITS_PER_CYCLE bits of the A and B shift registers plus the carry register through a ripple chain.
  - The slice result shifts into the sum shift register from the MSB end.
  - Operands shift right by BITS_PER_CYCLE; the carry register takes the chain's carry-out; the counter increments.
  - On the step with counter = STEPS-1:
    - sum, cout and ovf load from the completed shift register and the final carries. The carry into the MSB comes from the chain's second-to-last stage, or from the carry register when BITS_PER_CYCLE=1.
    - Next state is DONE.
- **DONE:**
  - done=1 for exactly one cycle.
  - Next state is IDLE unconditionally.
  - start is ignored in this state.
- start in RUN or DONE is ignored and has no side effects.
- Result outputs change only on the DONE-entry edge. They are never visible mid-operation.

## Timing
- Reset values (immediate, asynchronous):
  - state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal registers are 0.
- Latency:
  - start is sampled high at edge E0.
  - busy rises after E0.
  - The final step occurs at edge E0+STEPS.
  - done and the new results are visible in the cycle after edge E0+STEPS.
  - busy falls after edge E0+STEPS+1.
- Throughput: one operation per STEPS+2 cycles. The next start is accepted at the first edge where the state is IDLE.
- Reset asserted mid-RUN or in DONE aborts the operation. The aborted operation produces no done pulse, and results return to 0.
- STEPS=1 (BITS_PER_CYCLE=WIDTH): a single RUN cycle, then done.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - With sub=1, B is inverted on capture, the carry register initialises to 1, and cin is ignored; the result is a−b.
  - cout=1 means no borrow.
- Not defined: the sub port is absent and the block performs addition only.

## Structure
- Package serial_adder_pkg holds the state enum typedef (IDLE, RUN, DONE; 2-bit encoding).
- Width-derived constants (STEPS, counter width) are localparams in the module, because they depend on instance parameters.
- Sub-module fa_bit is a one-bit full adder (a, b, ci → s, co). It is instantiated BITS_PER_CYCLE times in a generate loop to form the slice ripple chain.

## Test plan
- WIDTH=1, BITS_PER_CYCLE=1, all 8 (a,b,cin) combinations. Each sum/cout must match the full-adder truth table (e.g. 1,1,1 → sum=1, cout=1), with done 1 cycle after the start edge.
- WIDTH=8, K=1, a=0x5A, b=0x3C, cin=0 → sum=0x96, cout=0, ovf=1, with done exactly 8 cycles after the start edge.
- WIDTH=8, K=1, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 → sum=0x01.
- WIDTH=8, K=4, a=0x7F, b=0x01 → sum=0x80, ovf=1, with done 2 cycles after the start edge. A start pulse held high during busy launches no second operation.
- Reset asserted 3 cycles into a K=1 run:
  - Immediately: busy=0, sum=0.
  - No done pulse occurs.
  - A fresh start a=0x01, b=0x02 → sum=0x03.
- With SERIAL_ADDER_SUB_EN, a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0, ovf=0. Then a=0x20, b=0x10 → sum=0x10, cout=1.
